// File: rtl/uart_tx_if.sv
// UART transmitter handshake bundle: request/data from the client, serial line and status back.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  // Client side: issues requests and observes the line/status.
  modport master (
    output tx_start, tx_data,
    input  tx, tx_busy, tx_done
  );

  // Transmitter side.
  modport slave (
    input  tx_start, tx_data,
    output tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit,
// each bit held for CLKS_PER_BIT clocks. All outputs are registered.
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       idx_q, idx_n;
  logic [7:0]       shreg_q, shreg_n;
  logic             tx_q, tx_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shreg_q <= shreg_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state and next-output logic; outputs are computed one edge ahead
  // so the registered line changes exactly on bit boundaries.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shreg_n = shreg_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n  = '0;
        idx_n  = '0;
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (bus.tx_start) begin
          state_n = START;
          shreg_n = bus.tx_data;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        busy_n = 1'b1;
        if (bit_end) begin
          cnt_n   = '0;
          state_n = DATA;
          tx_n    = shreg_q[0];
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        busy_n = 1'b1;
        if (bit_end) begin
          cnt_n = '0;
          if (idx_q == 3'd7) begin
            state_n = STOP;
            idx_n   = '0;
            tx_n    = 1'b1;
          end else begin
            idx_n   = idx_q + 3'd1;
            shreg_n = {1'b0, shreg_q[7:1]};
            tx_n    = shreg_q[1];
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        busy_n = 1'b1;
        if (bit_end) begin
          cnt_n  = '0;
          done_n = 1'b1;
          busy_n = 1'b0;
          // A pending request here starts the next start bit with no idle
          // gap; busy drops for the single done cycle and returns next edge.
          if (bus.tx_start) begin
            state_n = START;
            shreg_n = bus.tx_data;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT = 4.
module tb_uart_tx;
  localparam int C = 4;

  logic clk;
  logic reset;
  uart_tx_if bus();

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: time since acceptance decides which bit is on the line.
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_data   = 8'h00;
  bit         n_active, n_done;
  int         n_t;
  logic [7:0] n_data;

  always_comb begin
    n_active = m_active;
    n_done   = 1'b0;
    n_t      = m_t;
    n_data   = m_data;
    if (m_active) begin
      n_t = m_t + 1;
      if (n_t == 10 * C) begin
        n_active = 1'b0;
        n_done   = 1'b1;
      end
    end
    if (!n_active && bus.tx_start) begin
      n_active = 1'b1;
      n_t      = 0;
      n_data   = bus.tx_data;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
      m_data   <= 8'h00;
    end else begin
      m_active <= n_active;
      m_done   <= n_done;
      m_t      <= n_t;
      m_data   <= n_data;
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_data[b-1];
    return 1'b1;
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_tx",   {31'b0, bus.tx},      {31'b0, exp_tx()});
    check("cmp_busy", {31'b0, bus.tx_busy}, {31'b0, m_active && !m_done});
    check("cmp_done", {31'b0, bus.tx_done}, {31'b0, m_done});
  end

  logic s_tx   [0:99];
  logic s_busy [0:99];
  logic s_done [0:99];

  // Raise tx_start for one edge (or leave it high when keep=1); returns at E0+0.5.
  task automatic start_frame(input logic [7:0] d, input bit keep);
    @(negedge clk);
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    @(negedge clk);
    if (!keep) bus.tx_start = 1'b0;
  endtask

  // Sample n cycles starting at E0+0.5; mode injects per-test stimulus.
  task automatic capture(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      s_tx[k]   = bus.tx;
      s_busy[k] = bus.tx_busy;
      s_done[k] = bus.tx_done;
      if (mode == 1 && k == 12) begin bus.tx_start = 1'b1; bus.tx_data = 8'h3C; end
      if (mode == 1 && k == 13) bus.tx_start = 1'b0;
      if (mode == 2 && k == 20) bus.tx_data = 8'hFF;
      if (mode == 2 && k == 50) bus.tx_start = 1'b0;
      if (mode == 3 && k == 17) begin
        reset = 1'b0;
        #1;
        check("rst_imm_tx",   {31'b0, bus.tx},      32'd1);
        check("rst_imm_busy", {31'b0, bus.tx_busy}, 32'd0);
      end
      if (mode == 4) bus.tx_data = ~bus.tx_data;
      @(negedge clk);
    end
  endtask

  task automatic check_bits(input string name, input logic [7:0] d, input int base);
    logic e;
    for (int b = 0; b < 10; b++) begin
      e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
      check(name, {31'b0, s_tx[base + b*C + 1]}, {31'b0, e});
    end
  endtask

  function automatic int count_done(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (s_done[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic wait_idle();
    int w = 0;
    while ((bus.tx_busy !== 1'b0 || m_active) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("idle_timeout", {31'b0, w >= 100}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  logic [9:0] a5_line = 10'b1101001010;
  logic [7:0] x5a_bits = 8'b01011010;
  int busy_cnt;

  initial begin
    reset        = 1'b0;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_tx",   {31'b0, bus.tx},      32'd1);
    check("reset_busy", {31'b0, bus.tx_busy}, 32'd0);
    check("reset_done", {31'b0, bus.tx_done}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single 0xA5 frame.
    start_frame(8'hA5, 1'b0);
    capture(44, 0);
    for (int b = 0; b < 10; b++)
      check("a5_line", {31'b0, s_tx[b*C + 1]}, {31'b0, a5_line[b]});
    busy_cnt = 0;
    for (int k = 0; k < 44; k++) if (s_busy[k] === 1'b1) busy_cnt++;
    check("a5_busy_cycles", busy_cnt, 32'd40);
    check("a5_done_count", count_done(44), 32'd1);
    check("a5_done_at_40", {31'b0, s_done[40]}, 32'd1);
    wait_idle();

    // Request during busy is dropped.
    start_frame(8'hA5, 1'b0);
    capture(60, 1);
    check_bits("rej_bits", 8'hA5, 0);
    check("rej_done_count", count_done(60), 32'd1);
    check("rej_idle_after", {31'b0, s_busy[50]}, 32'd0);
    wait_idle();

    // tx_start held high: two frames, zero gap.
    start_frame(8'h00, 1'b1);
    capture(84, 2);
    check_bits("b2b_f1", 8'h00, 0);
    check_bits("b2b_f2", 8'hFF, 40);
    check("b2b_gap_tx", {31'b0, s_tx[40]}, 32'd0);
    check("b2b_done_40", {31'b0, s_done[40]}, 32'd1);
    check("b2b_done_80", {31'b0, s_done[80]}, 32'd1);
    check("b2b_done_count", count_done(84), 32'd2);
    check("b2b_busy_gap", {31'b0, s_busy[40]}, 32'd0);
    wait_idle();

    // Reset mid-frame, then a clean 0x81 frame accepted on the first edge.
    start_frame(8'hC3, 1'b0);
    capture(30, 3);
    check("rst_done_count", count_done(30), 32'd0);
    check("rst_tx_held", {31'b0, s_tx[25]}, 32'd1);
    check("rst_busy_held", {31'b0, s_busy[25]}, 32'd0);
    reset        = 1'b1;
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'h81;
    @(negedge clk);
    bus.tx_start = 1'b0;
    capture(44, 0);
    check_bits("rst_81_bits", 8'h81, 0);
    check("rst_81_done_40", {31'b0, s_done[40]}, 32'd1);
    wait_idle();

    // Data bus toggling after acceptance must not leak into the frame.
    start_frame(8'h5A, 1'b0);
    capture(44, 4);
    for (int b = 0; b < 8; b++)
      check("stab_5a", {31'b0, s_tx[(b+1)*C + 1]}, {31'b0, x5a_bits[b]});
    check("stab_done_count", count_done(44), 32'd1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
